piso_shift_tx: RTL
==================

Name: piso_shift_tx

Overview:
Parallel-in, serial-out shift transmitter. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock. It is the transmit end of the team's serial-in shift register links. The default LSB-first order means a downstream serial-in register that shifts toward bit 0 holds the original word after WIDTH shifts.

Parameters:
WIDTH, 4, word length in bits; legal range WIDTH >= 2.
MSB_FIRST, 0, 0 = bit 0 transmitted first; 1 = bit WIDTH-1 transmitted first.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst_n  input  1  asynchronous, active-low reset.
din  input  WIDTH  parallel word to transmit.
load_valid  input  1  din is valid for loading.
load_ready  output  1  block can accept a word this cycle.
shift_en  input  1  advance to next bit at this edge; pacing/stall control.
sout  output  1  current serial bit.
sout_valid  output  1  sout carries a valid data bit.
last  output  1  sout is the final bit of the current word.
busy  output  1  word in flight (state SHIFT).
done  output  1  one-cycle pulse, cycle after final bit consumed.

Behaviour:
- Reset (async, rst_n=0): state IDLE, shift reg=0, bit count=0, sout=0, sout_valid=0, last=0, busy=0, done=0; load_ready=1 as soon as rst_n=1. Reset mid-word aborts the word; the remaining bits are discarded and no done pulse occurs.
- States: IDLE, SHIFT. Bit counter width is $clog2(WIDTH) and counts 0..WIDTH-1.
- load_ready (combinational) = (state==IDLE) || (last && shift_en).
- Accept = load_valid && load_ready at a posedge. din is sampled only on accept. load_valid while not ready is ignored, and din is not sampled.
- IDLE: shift_en is ignored, sout=0, sout_valid=0. On accept: capture din, count=0, go to SHIFT.
- Latency: the first bit appears on sout, with sout_valid=1, in the cycle after accept.
- SHIFT: sout = bit[count] for LSB-first, or bit[WIDTH-1-count] for MSB_FIRST=1. sout, sout_valid and last are held stable while shift_en=0, for an unlimited stall.
- Advance: on a posedge with shift_en=1, count increments.
- last = (count==WIDTH-1) in SHIFT.
- Final bit: on a posedge with shift_en=1 and last=1, the word is complete, and done=1 for the next cycle only.
  - If accept occurs on the same edge (back-to-back), the new word is captured, count=0 and state stays SHIFT. The new word's first bit follows the old last bit with no gap; busy and sout_valid stay 1.
  - Otherwise, return to IDLE: sout_valid=0, sout=0, busy=0.
- Throughput: with shift_en held 1 and continuous load_valid, one word every WIDTH cycles with zero idle bits.
- All outputs except load_ready are registered or decoded directly from registered state, so there is no combinational path from din to sout.

Test Plan:
1. Reset, WIDTH=4, MSB_FIRST=0: load din=4'b1011, shift_en=1 -> sout=1,1,0,1 on cycles 1-4 after accept; last high on cycle 4 only; done pulse on cycle 5; busy=0 and sout_valid=0 on cycle 5.
2. MSB_FIRST=1, din=4'b1000 -> sout=1,0,0,0. Loopback into a 4-bit serial-in register shifting toward bit 0 with MSB_FIRST=0, din=4'hA -> register reads 4'hA after 4 shifts.
3. Stall: shift_en=0 for 3 cycles after bit 1 -> sout, last and count frozen; then the sequence resumes intact; total of 4 enabled advances before done.
4. Back-to-back: load_valid held 1, din=4'h5 then 4'h3 -> load_ready=1 on the last-bit cycle; serial stream 1,0,1,0,1,1,0,0 with no gap; sout_valid stays 1; done pulses once per word.
5. Busy load attempt: pulse load_valid with din=4'hF on bit 2 of word 4'h0 -> ignored; the stream stays 0,0,0,0; load_ready=0 during that cycle.
6. Async reset mid-word: drop rst_n between edges during bit 2 -> sout, sout_valid, busy and last go to 0 immediately; no done pulse; load_ready=1 after release.

Source files
------------

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out shift transmitter.
//
// A WIDTH-bit word is accepted through a valid/ready handshake. It is then
// presented one bit per cycle on sout, and the next bit is selected on every
// clock edge where shift_en is high. Bit order is LSB-first by default and
// MSB-first when MSB_FIRST=1. A new word may be accepted on the same edge
// that consumes the final bit, so the stream has no gap between words.
//
// Ports:
//   clk        - single clock; all state updates on posedge
//   rst_n      - asynchronous active-low reset
//   din        - parallel word, sampled only on accept
//   load_valid - din is valid for loading
//   load_ready - a word can be accepted this cycle (combinational)
//   shift_en   - advance to the next bit at this edge (stall when low)
//   sout       - current serial bit (0 when idle)
//   sout_valid - sout carries a data bit
//   last       - sout is the final bit of the current word
//   busy       - a word is in flight
//   done       - one-cycle pulse after the final bit has been consumed

module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic [CW-1:0]    bit_idx;
  logic             at_last;
  logic             word_end;
  logic             accept;

  // The ready term for the final bit lets a new word slip in on the very
  // edge that retires the old one, which is what removes the idle gap.
  assign at_last    = (state == SHIFT) && (count == LAST_CNT);
  assign word_end   = at_last && shift_en;
  assign load_ready = (state == IDLE) || word_end;
  assign accept     = load_valid && load_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Leaving SHIFT happens only when the final bit is
  // consumed and no replacement word arrives on that same edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SHIFT;
      end
      SHIFT: begin
        if (word_end && !accept) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: the word is held unshifted and the counter selects the bit,
  // so a stall simply freezes the counter. The done pulse is registered from
  // the final-bit condition so it lands in the cycle after that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= word_end;
      if (accept) begin
        shreg <= din;
        count <= '0;
      end else if (word_end) begin
        count <= '0;
      end else if ((state == SHIFT) && shift_en) begin
        count <= count + 1'b1;
      end
    end
  end

  // Output decode. Everything here comes from registered state only, so
  // there is no combinational path from din to sout.
  always_comb begin
    bit_idx    = MSB_FIRST ? (LAST_CNT - count) : count;
    busy       = (state == SHIFT);
    sout_valid = (state == SHIFT);
    last       = at_last;
    sout       = (state == SHIFT) ? shreg[bit_idx] : 1'b0;
  end

endmodule
